// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    FETCH,
    HOLD,
    DISCARD
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam int unsigned PC_INC    = 4;

endpackage

// File: rtl/fetch_unit.sv
// PC register and single-outstanding instruction fetch with one-entry decode buffer.
// Redirects (je) kill wrong-path work; a redirect during an outstanding read waits in DISCARD.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned      XLEN         = 32,
  parameter logic [XLEN-1:0]  RESET_VECTOR = '0
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            je,
  input  logic [XLEN-1:0] je_target,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [31:0]     instr,
  output logic [XLEN-1:0] instr_pc
);

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] redir_pc_q, redir_pc_d;
  logic [XLEN-1:0] instr_pc_q, instr_pc_d;
  logic [31:0]     instr_q, instr_d;
  logic            instr_valid_q, instr_valid_d;
  logic [XLEN-1:0] target_aligned;

  assign target_aligned = {je_target[XLEN-1:2], 2'b00};

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    redir_pc_d    = redir_pc_q;
    instr_pc_d    = instr_pc_q;
    instr_d       = instr_q;
    instr_valid_d = instr_valid_q;
    unique case (state_q)
      FETCH: begin
        if (je && imem_ack) begin
          pc_d = target_aligned;
        end else if (je) begin
          redir_pc_d = target_aligned;
          state_d    = DISCARD;
        end else if (imem_ack) begin
          instr_d       = imem_rdata;
          instr_pc_d    = pc_q;
          pc_d          = pc_q + XLEN'(PC_INC);
          instr_valid_d = 1'b1;
          state_d       = HOLD;
        end
      end
      HOLD: begin
        if (je) begin
          instr_valid_d = 1'b0;
          pc_d          = target_aligned;
          state_d       = FETCH;
        end else if (instr_ready) begin
          instr_valid_d = 1'b0;
          state_d       = FETCH;
        end
      end
      DISCARD: begin
        // The stale read must complete before refetching; the newest redirect wins.
        if (imem_ack) begin
          pc_d    = je ? target_aligned : redir_pc_q;
          state_d = FETCH;
        end else if (je) begin
          redir_pc_d = target_aligned;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= FETCH;
      pc_q          <= RESET_VECTOR;
      redir_pc_q    <= '0;
      instr_pc_q    <= '0;
      instr_q       <= NOP_INSTR;
      instr_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      redir_pc_q    <= redir_pc_d;
      instr_pc_q    <= instr_pc_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
    end
  end

  assign imem_req    = reset_n && (state_q == FETCH || state_q == DISCARD);
  assign imem_addr   = pc_q;
  assign instr_valid = instr_valid_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;

  ack_only_when_requested: assert property (
    @(posedge clk) disable iff (!reset_n) imem_ack |-> (state_q != HOLD)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        je;
  logic [31:0] je_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;

  int total = 0;
  int bad   = 0;

  fetch_unit #(.XLEN(32), .RESET_VECTOR(32'h0000_0000)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .je          (je),
    .je_target   (je_target),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .instr_pc    (instr_pc)
  );

  always #5 clk = ~clk;

  // Advance one rising edge; inputs change and outputs are sampled 1ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; je = 1'b0; je_target = '0; imem_ack = 1'b0;
    imem_rdata = '0; instr_ready = 1'b0;
    step();
    step();
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL rst_req_low got=%b exp=0", imem_req); end
    reset_n = 1'b1;
    #1;
    total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL rst_req got=%b exp=1", imem_req); end
    total++; if (imem_addr !== 32'h0) begin bad++; $display("FAIL rst_addr got=%h exp=00000000", imem_addr); end
    total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", instr_valid); end
    total++; if (instr !== 32'h0000_0013) begin bad++; $display("FAIL rst_instr got=%h exp=00000013", instr); end
    total++; if (instr_pc !== 32'h0) begin bad++; $display("FAIL rst_instr_pc got=%h exp=00000000", instr_pc); end
  endtask

  task automatic test_first_fetch();
    for (int i = 0; i < 3; i++) begin
      step();
      total++; if (imem_addr !== 32'h0 || imem_req !== 1'b1) begin
        bad++; $display("FAIL ff_wait_addr got=%h/%b exp=00000000/1", imem_addr, imem_req);
      end
    end
    imem_ack = 1'b1; imem_rdata = 32'h0050_0093; instr_ready = 1'b1;
    step();
    imem_ack = 1'b0; imem_rdata = '0;
    total++; if (instr_valid !== 1'b1) begin bad++; $display("FAIL ff_valid got=%b exp=1", instr_valid); end
    total++; if (instr !== 32'h0050_0093) begin bad++; $display("FAIL ff_instr got=%h exp=00500093", instr); end
    total++; if (instr_pc !== 32'h0) begin bad++; $display("FAIL ff_instr_pc got=%h exp=00000000", instr_pc); end
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL ff_hold_req got=%b exp=0", imem_req); end
    step();
    total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL ff_valid_drop got=%b exp=0", instr_valid); end
    total++; if (imem_addr !== 32'h4 || imem_req !== 1'b1) begin
      bad++; $display("FAIL ff_next_addr got=%h/%b exp=00000004/1", imem_addr, imem_req);
    end
    instr_ready = 1'b0;
  endtask

  task automatic test_hold_stall();
    imem_ack = 1'b1; imem_rdata = 32'h00A0_0113;
    step();
    imem_ack = 1'b0; imem_rdata = 32'hDEAD_BEEF;
    for (int i = 0; i < 5; i++) begin
      step();
      total++; if (instr_valid !== 1'b1 || instr !== 32'h00A0_0113 || instr_pc !== 32'h4 || imem_req !== 1'b0) begin
        bad++; $display("FAIL hold_stable cyc=%0d got v=%b i=%h pc=%h req=%b exp v=1 i=00a00113 pc=00000004 req=0",
                        i, instr_valid, instr, instr_pc, imem_req);
      end
    end
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL hold_release_valid got=%b exp=0", instr_valid); end
    total++; if (imem_addr !== 32'h8 || imem_req !== 1'b1) begin
      bad++; $display("FAIL hold_next_addr got=%h/%b exp=00000008/1", imem_addr, imem_req);
    end
  endtask

  task automatic test_double_redirect();
    je = 1'b1; je_target = 32'h0000_0040;
    step();
    total++; if (imem_addr !== 32'h8 || imem_req !== 1'b1) begin
      bad++; $display("FAIL dr_stale_addr got=%h/%b exp=00000008/1", imem_addr, imem_req);
    end
    je_target = 32'h0000_0080;
    step();
    je = 1'b0; je_target = '0;
    total++; if (instr_valid !== 1'b0 || imem_addr !== 32'h8) begin
      bad++; $display("FAIL dr_discard got v=%b addr=%h exp v=0 addr=00000008", instr_valid, imem_addr);
    end
    step();
    imem_ack = 1'b1; imem_rdata = 32'hBAD0_BAD0;
    step();
    imem_ack = 1'b0;
    total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL dr_dropped got=%b exp=0", instr_valid); end
    total++; if (imem_addr !== 32'h80 || imem_req !== 1'b1) begin
      bad++; $display("FAIL dr_target_addr got=%h/%b exp=00000080/1", imem_addr, imem_req);
    end
  endtask

  task automatic test_hold_redirect();
    imem_ack = 1'b1; imem_rdata = 32'h1111_1111;
    step();
    imem_ack = 1'b0;
    total++; if (instr_valid !== 1'b1 || instr_pc !== 32'h80) begin
      bad++; $display("FAIL hr_fill got v=%b pc=%h exp v=1 pc=00000080", instr_valid, instr_pc);
    end
    je = 1'b1; je_target = 32'h0000_0103; instr_ready = 1'b1;
    step();
    je = 1'b0; je_target = '0; instr_ready = 1'b0;
    total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL hr_killed got=%b exp=0", instr_valid); end
    total++; if (imem_addr !== 32'h100 || imem_req !== 1'b1) begin
      bad++; $display("FAIL hr_addr got=%h/%b exp=00000100/1", imem_addr, imem_req);
    end
    imem_ack = 1'b1; imem_rdata = 32'h2222_2222;
    step();
    imem_ack = 1'b0;
    total++; if (instr_pc !== 32'h100 || instr !== 32'h2222_2222) begin
      bad++; $display("FAIL hr_refetch got pc=%h i=%h exp pc=00000100 i=22222222", instr_pc, instr);
    end
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
  endtask

  task automatic test_wrap_and_je_ack();
    // je together with ack: data dropped, target (low bits cleared) fetched next.
    je = 1'b1; je_target = 32'hFFFF_FFFF; imem_ack = 1'b1; imem_rdata = 32'h3333_3333;
    step();
    je = 1'b0; je_target = '0; imem_ack = 1'b0;
    total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL wa_je_ack_valid got=%b exp=0", instr_valid); end
    total++; if (imem_addr !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wa_je_ack_addr got=%h exp=fffffffc", imem_addr); end
    imem_ack = 1'b1; imem_rdata = 32'h0000_0073;
    step();
    imem_ack = 1'b0;
    total++; if (instr_pc !== 32'hFFFF_FFFC || instr_valid !== 1'b1) begin
      bad++; $display("FAIL wa_top_pc got pc=%h v=%b exp pc=fffffffc v=1", instr_pc, instr_valid);
    end
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    total++; if (imem_addr !== 32'h0) begin bad++; $display("FAIL wa_wrap_addr got=%h exp=00000000", imem_addr); end
    je = 1'b1; je_target = 32'h0000_0200; imem_ack = 1'b1;
    step();
    je = 1'b0; imem_ack = 1'b0;
    total++; if (instr_valid !== 1'b0 || imem_addr !== 32'h200) begin
      bad++; $display("FAIL wa_je_ack2 got v=%b addr=%h exp v=0 addr=00000200", instr_valid, imem_addr);
    end
  endtask

  task automatic test_reset_mid_request();
    je = 1'b1; je_target = 32'h0000_0300;
    step();
    je = 1'b0;
    reset_n = 1'b0;
    step();
    total++; if (imem_req !== 1'b0 || instr_valid !== 1'b0 || instr !== 32'h0000_0013) begin
      bad++; $display("FAIL rm_reset got req=%b v=%b i=%h exp req=0 v=0 i=00000013", imem_req, instr_valid, instr);
    end
    reset_n = 1'b1;
    #1;
    total++; if (imem_addr !== 32'h0 || imem_req !== 1'b1) begin
      bad++; $display("FAIL rm_addr got=%h/%b exp=00000000/1", imem_addr, imem_req);
    end
  endtask

  initial begin
    test_reset();
    test_first_fetch();
    test_hold_stall();
    test_double_redirect();
    test_hold_redirect();
    test_wrap_and_je_ack();
    test_reset_mid_request();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
